vga_cursor_engine: RTL and testbench

- Parametrised VGA timing generator with a square cursor overlay; drives the board VGA connector directly.
- Successor to the fixed 640x480 mouse display. Adds:
  - generic timing and divider;
  - reset;
  - correct vertical counting;
  - tear-free cursor position latching;
  - edge-safe cursor arithmetic;
  - programmable cursor and background colours;
  - blanking, pixel coordinates and frame-start status to the rest of the SoC.

---
 rtl/vga_cursor_engine_if.sv | 37 +++
 rtl/vga_cursor_engine.sv | 164 ++++++++++++++++
 tb/tb_vga_cursor_engine.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_cursor_engine_if.sv
`default_nettype none
// ============================================================================
// vga_cursor_engine_if : cursor/colour controls in, VGA pins and status out
// Revision: 1.0
// ============================================================================
interface vga_cursor_engine_if #(
    parameter int POS_W   = 16,
    parameter int COLOR_W = 4
);
    logic [POS_W-1:0]     cursor_x;
    logic [POS_W-1:0]     cursor_y;
    logic                 cursor_en;
    logic [3*COLOR_W-1:0] cursor_rgb;
    logic [3*COLOR_W-1:0] bg_rgb;
    logic [COLOR_W-1:0]   vga_o_red;
    logic [COLOR_W-1:0]   vga_o_green;
    logic [COLOR_W-1:0]   vga_o_blue;
    logic                 h_sync;
    logic                 v_sync;
    logic                 active;
    logic                 frame_start;
    logic [POS_W-1:0]     pix_x;
    logic [POS_W-1:0]     pix_y;

    modport master (
        output cursor_x, cursor_y, cursor_en, cursor_rgb, bg_rgb,
        input  vga_o_red, vga_o_green, vga_o_blue, h_sync, v_sync,
        input  active, frame_start, pix_x, pix_y
    );

    modport slave (
        input  cursor_x, cursor_y, cursor_en, cursor_rgb, bg_rgb,
        output vga_o_red, vga_o_green, vga_o_blue, h_sync, v_sync,
        output active, frame_start, pix_x, pix_y
    );
endinterface
`default_nettype wire

// File: rtl/vga_cursor_engine.sv
`default_nettype none
// ============================================================================
// vga_cursor_engine : parametrised VGA timing with a frame-latched square cursor
// Revision: 1.0
// ============================================================================
module vga_cursor_engine #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CURSOR_HALF = 4,
    parameter int COLOR_W     = 4,
    parameter int POS_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_cursor_engine_if.slave bus
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_OFF   = H_SYNC + H_BP;
    localparam int V_OFF   = V_SYNC + V_BP;
    localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int SW      = POS_W + 2;
    localparam int RGB_W   = 3 * COLOR_W;

    logic w_pe;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            logic [DW-1:0] r_div_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_div_cnt <= '0;
                end else if (r_div_cnt == DW'(CLK_DIV - 1)) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + DW'(1);
                end
            end

            assign w_pe = (r_div_cnt == DW'(CLK_DIV - 1));
        end else begin : g_nodiv
            assign w_pe = 1'b1;
        end
    endgenerate

    logic [HC_W-1:0]  r_h_cnt;
    logic [VC_W-1:0]  r_v_cnt;
    logic [POS_W-1:0] r_cx;
    logic [POS_W-1:0] r_cy;
    logic             r_cen;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame0;

    assign w_h_last = (r_h_cnt == HC_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VC_W'(V_TOTAL - 1));
    assign w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Cursor inputs are sampled once per frame so a mid-frame move cannot tear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_cen   <= 1'b0;
        end else if (w_pe) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + HC_W'(1);
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
            end
            if (w_frame0) begin
                r_cx  <= bus.cursor_x;
                r_cy  <= bus.cursor_y;
                r_cen <= bus.cursor_en;
            end
        end
    end

    // Two guard bits keep col-cx signed and free of wrap for any cursor value
    logic signed [SW-1:0] w_col;
    logic signed [SW-1:0] w_row;
    logic signed [SW-1:0] w_dx;
    logic signed [SW-1:0] w_dy;
    logic signed [SW-1:0] w_adx;
    logic signed [SW-1:0] w_ady;
    logic                 w_hit;
    logic                 w_hs_raw;
    logic                 w_vs_raw;
    logic                 w_act_raw;

    assign w_col  = $signed({{(SW-HC_W){1'b0}}, r_h_cnt}) - $signed(SW'(H_OFF));
    assign w_row  = $signed({{(SW-VC_W){1'b0}}, r_v_cnt}) - $signed(SW'(V_OFF));
    assign w_dx   = w_col - $signed({2'b00, r_cx});
    assign w_dy   = w_row - $signed({2'b00, r_cy});
    assign w_adx  = w_dx[SW-1] ? -w_dx : w_dx;
    assign w_ady  = w_dy[SW-1] ? -w_dy : w_dy;
    assign w_hit  = (w_adx < $signed(SW'(CURSOR_HALF))) &&
                    (w_ady < $signed(SW'(CURSOR_HALF)));

    assign w_hs_raw  = (r_h_cnt < HC_W'(H_SYNC));
    assign w_vs_raw  = (r_v_cnt < VC_W'(V_SYNC));
    assign w_act_raw = !w_col[SW-1] && (w_col < $signed(SW'(H_ACTIVE))) &&
                       !w_row[SW-1] && (w_row < $signed(SW'(V_ACTIVE)));

    logic [RGB_W-1:0] r_rgb;
    logic             r_hs;
    logic             r_vs;
    logic             r_act;
    logic             r_fs;
    logic [POS_W-1:0] r_px;
    logic [POS_W-1:0] r_py;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_act <= 1'b0;
            r_fs  <= 1'b0;
            r_px  <= '0;
            r_py  <= '0;
        end else begin
            r_fs <= w_pe && w_frame0;
            if (w_pe) begin
                if (w_act_raw && w_hit && r_cen) begin
                    r_rgb <= bus.cursor_rgb;
                end else if (w_act_raw) begin
                    r_rgb <= bus.bg_rgb;
                end else begin
                    r_rgb <= '0;
                end
                r_hs  <= ~w_hs_raw;
                r_vs  <= ~w_vs_raw;
                r_act <= w_act_raw;
                r_px  <= w_act_raw ? w_col[POS_W-1:0] : '0;
                r_py  <= w_act_raw ? w_row[POS_W-1:0] : '0;
            end
        end
    end

    assign bus.vga_o_red   = r_rgb[RGB_W-1 -: COLOR_W];
    assign bus.vga_o_green = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.vga_o_blue  = r_rgb[COLOR_W-1:0];
    assign bus.h_sync      = r_hs;
    assign bus.v_sync      = r_vs;
    assign bus.active      = r_act;
    assign bus.frame_start = r_fs;
    assign bus.pix_x       = r_px;
    assign bus.pix_y       = r_py;

endmodule
`default_nettype wire

// File: tb/tb_vga_cursor_engine.sv
`default_nettype none
// ============================================================================
// tb_vga_cursor_engine : two reduced-timing engines against a slot-index model
// Revision: 1.0
// ============================================================================
module tb_vga_cursor_engine;

    typedef struct packed {
        int cd; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
    } timing_t;

    typedef struct packed {
        int          cyc;
        int          p;
        int          sx;
        int          sy;
        bit          sen;
        logic [47:0] expv;
    } model_t;

    localparam int CH   = 4;
    localparam int A_CD = 4, A_HA = 32, A_HF = 3, A_HS = 4, A_HB = 4;
    localparam int A_VA = 24, A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam int FA   = A_HT * A_VT * A_CD;
    localparam int B_CD = 1, B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;

    timing_t ta = '{A_CD, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB};
    timing_t tb = '{B_CD, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB};

    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    bit   done;
    bit   started;
    int   n_cmp;
    int   n_err;

    vga_cursor_engine_if #(.POS_W(16), .COLOR_W(4)) ifa ();
    vga_cursor_engine_if #(.POS_W(16), .COLOR_W(4)) ifb ();

    vga_cursor_engine #(
        .CLK_DIV(A_CD), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .CURSOR_HALF(CH), .COLOR_W(4), .POS_W(16)
    ) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa));

    vga_cursor_engine #(
        .CLK_DIV(B_CD), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .CURSOR_HALF(CH), .COLOR_W(4), .POS_W(16)
    ) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel slot p (0-based count of pixel periods since reset release) maps
    // to line p/H_TOTAL and column p%H_TOTAL; frame cursor state is sampled at slot 0.
    function automatic model_t model_step(input model_t m, input timing_t t, input bit rstn,
                                          input int cx, input int cy, input bit cen,
                                          input logic [11:0] crgb, input logic [11:0] bg);
        model_t      r;
        int          ht, vt, h, v, col, row, dx, dy;
        bit          act, hit;
        logic [11:0] rgb;
        logic [15:0] px, py;
        r = m;
        if (!rstn) begin
            r.cyc  = 0;
            r.p    = 0;
            r.sx   = 0;
            r.sy   = 0;
            r.sen  = 1'b0;
            r.expv = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        end else begin
            r.cyc      = m.cyc + 1;
            r.expv[32] = 1'b0;
            if (r.cyc % t.cd == 0) begin
                ht = t.hs + t.hb + t.ha + t.hf;
                vt = t.vs + t.vb + t.va + t.vf;
                h  = r.p % ht;
                v  = (r.p / ht) % vt;
                if (h == 0 && v == 0) begin
                    r.sx  = cx;
                    r.sy  = cy;
                    r.sen = cen;
                end
                col = h - (t.hs + t.hb);
                row = v - (t.vs + t.vb);
                act = (col >= 0) && (col < t.ha) && (row >= 0) && (row < t.va);
                dx  = col - r.sx;
                dy  = row - r.sy;
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                hit = (dx < CH) && (dy < CH);
                rgb = !act ? 12'h000 : ((hit && r.sen) ? crgb : bg);
                px  = act ? 16'(col) : 16'h0000;
                py  = act ? 16'(row) : 16'h0000;
                r.expv = {rgb, (h >= t.hs), (v >= t.vs), act, (h == 0 && v == 0), px, py};
                r.p = r.p + 1;
            end
        end
        return r;
    endfunction

    function automatic int exp_cursor_px(input int sx, input int sy, input bit en, input timing_t t);
        int nc, nr;
        nc = 0;
        nr = 0;
        for (int c = 0; c < t.ha; c++) if ((c - sx < CH) && (sx - c < CH)) nc++;
        for (int r = 0; r < t.va; r++) if ((r - sy < CH) && (sy - r < CH)) nr++;
        return en ? nc * nr : 0;
    endfunction

    model_t      ma, mb;
    logic [47:0] obs_a, obs_b;

    assign obs_a = {ifa.vga_o_red, ifa.vga_o_green, ifa.vga_o_blue, ifa.h_sync, ifa.v_sync,
                    ifa.active, ifa.frame_start, ifa.pix_x, ifa.pix_y};
    assign obs_b = {ifb.vga_o_red, ifb.vga_o_green, ifb.vga_o_blue, ifb.h_sync, ifb.v_sync,
                    ifb.active, ifb.frame_start, ifb.pix_x, ifb.pix_y};

    initial begin
        forever begin
            @(posedge clk);
            ma = model_step(ma, ta, rst_n_a, int'(ifa.cursor_x), int'(ifa.cursor_y),
                            ifa.cursor_en, ifa.cursor_rgb, ifa.bg_rgb);
            mb = model_step(mb, tb, rst_n_b, int'(ifb.cursor_x), int'(ifb.cursor_y),
                            ifb.cursor_en, ifb.cursor_rgb, ifb.bg_rgb);
            started = 1'b1;
        end
    end

    int frames_a, frames_b;
    int a_clks, a_act, a_hsl, a_vsl, a_cur, a_psx, a_psy;
    bit a_pen, a_have_prev, a_have_first;
    int b_clks, b_lclks;
    bit b_have_prev, b_have_line, b_prev_hs;

    initial begin
        b_prev_hs = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                check("a_pixel_out", obs_a, ma.expv);
                check("b_pixel_out", obs_b, mb.expv);

                if (!rst_n_a) begin
                    a_have_prev  = 1'b0;
                    a_have_first = 1'b0;
                end else begin
                    if (ifa.frame_start) begin
                        if (!a_have_first) begin
                            check("a_fs_after_rst_clk", ma.cyc, A_CD);
                            a_have_first = 1'b1;
                        end
                        if (a_have_prev) begin
                            check("a_frame_clks", a_clks, FA);
                            check("a_active_clks", a_act, A_HA * A_VA * A_CD);
                            check("a_hsync_low_clks", a_hsl, A_HS * A_CD * A_VT);
                            check("a_vsync_low_clks", a_vsl, A_VS * A_HT * A_CD);
                            check("a_cursor_clks", a_cur, exp_cursor_px(a_psx, a_psy, a_pen, ta) * A_CD);
                            frames_a++;
                        end
                        a_have_prev = 1'b1;
                        a_clks = 0; a_act = 0; a_hsl = 0; a_vsl = 0; a_cur = 0;
                        a_psx = ma.sx; a_psy = ma.sy; a_pen = ma.sen;
                    end
                    a_clks++;
                    if (ifa.active) a_act++;
                    if (!ifa.h_sync) a_hsl++;
                    if (!ifa.v_sync) a_vsl++;
                    if (ifa.active && {ifa.vga_o_red, ifa.vga_o_green, ifa.vga_o_blue} == 12'hF00) a_cur++;
                end

                if (!rst_n_b) begin
                    b_have_prev = 1'b0;
                    b_have_line = 1'b0;
                    b_prev_hs   = 1'b1;
                end else begin
                    if (ifb.frame_start) begin
                        if (b_have_prev) begin
                            check("b_frame_clks", b_clks, 98);
                            frames_b++;
                        end
                        b_have_prev = 1'b1;
                        b_clks = 0;
                    end
                    b_clks++;
                    if (b_prev_hs && !ifb.h_sync) begin
                        if (b_have_line) check("b_line_clks", b_lclks, 14);
                        b_have_line = 1'b1;
                        b_lclks = 0;
                    end
                    b_lclks++;
                    b_prev_hs = ifb.h_sync;
                end
            end
        end
    end

    // Engine B gets continuously changing cursor and colours, including far-off positions
    initial begin
        ifb.cursor_x   = 16'd3;
        ifb.cursor_y   = 16'd1;
        ifb.cursor_en  = 1'b1;
        ifb.cursor_rgb = 12'h0F0;
        ifb.bg_rgb     = 12'h111;
        while (!done) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            ifb.cursor_x   = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom_range(0, 11));
            ifb.cursor_y   = 16'($urandom_range(0, 7));
            ifb.cursor_en  = ($urandom_range(0, 3) != 0);
            ifb.cursor_rgb = 12'($urandom_range(0, 4095));
            ifb.bg_rgb     = 12'($urandom_range(0, 4095));
        end
    end

    int tx [6] = '{25, 0, 31, 100, 65533, 20};
    int ty [6] = '{10, 0, 23, 100, 2, 10};
    bit ten[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n_a        = 1'b0;
        rst_n_b        = 1'b0;
        ifa.cursor_x   = 16'd20;
        ifa.cursor_y   = 16'd10;
        ifa.cursor_en  = 1'b1;
        ifa.cursor_rgb = 12'hF00;
        ifa.bg_rgb     = 12'h00F;
        repeat (5) @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (FA / 2) @(negedge clk);

        // Each update lands mid-frame and must only show from the next frame
        for (int i = 0; i < 6; i++) begin
            ifa.cursor_x  = 16'(tx[i]);
            ifa.cursor_y  = 16'(ty[i]);
            ifa.cursor_en = ten[i];
            repeat (FA) @(negedge clk);
            if (i == 2) begin
                rst_n_b = 1'b0;
                repeat (3) @(negedge clk);
                rst_n_b = 1'b1;
            end
        end

        repeat (FA / 3) @(negedge clk);
        rst_n_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;

        for (int i = 0; i < 2; i++) begin
            ifa.cursor_x  = 16'($urandom_range(0, 40));
            ifa.cursor_y  = 16'($urandom_range(0, 30));
            ifa.cursor_en = 1'($urandom_range(0, 1));
            repeat (FA) @(negedge clk);
        end
        repeat (FA / 2) @(negedge clk);
        done = 1'b1;
        #1;

        check("a_frames_checked_ge6", (frames_a >= 6), 1);
        check("b_frames_checked_ge100", (frames_b >= 100), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
